// File: rtl/mix_pkg.sv
// Shared mixer/CIC constants and the signed sample type used across the mixer path.
package mix_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int CIC_N     = 3;
  localparam int CIC_RLOG2 = 4;
  localparam int CIC_GW    = SAMPLE_W + CIC_N * CIC_RLOG2;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/mix_cic_dec_if.sv
// Sample bus between the I/Q mixer, the CIC decimator and the phase/error stage.
interface mix_cic_dec_if;
  import mix_pkg::*;

  logic    IN_VALID;
  sample_t MIX1_DATI;
  sample_t MIX1_DATQ;
  sample_t MIX2_DATI;
  sample_t MIX2_DATQ;
  sample_t BB1_DATI;
  sample_t BB1_DATQ;
  sample_t BB2_DATI;
  sample_t BB2_DATQ;
  logic    OUT_VALID;

  modport master (
    output IN_VALID, MIX1_DATI, MIX1_DATQ, MIX2_DATI, MIX2_DATQ,
    input  BB1_DATI, BB1_DATQ, BB2_DATI, BB2_DATQ, OUT_VALID
  );

  modport slave (
    input  IN_VALID, MIX1_DATI, MIX1_DATQ, MIX2_DATI, MIX2_DATQ,
    output BB1_DATI, BB1_DATQ, BB2_DATI, BB2_DATQ, OUT_VALID
  );

endinterface

// File: rtl/mix_cic_ch.sv
// One CIC channel: three wrapping integrators at input rate, three combs at the
// decimated rate, then round-half-up rescale by R^3 with a saturation guard.
module mix_cic_ch
  import mix_pkg::*;
#(
  parameter int DW    = SAMPLE_W,
  parameter int RLOG2 = CIC_RLOG2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] x,
  input  logic [3:0]           en,
  output logic signed [DW-1:0] y
);

  localparam int SH = CIC_N * RLOG2;
  localparam int GW = DW + SH;
  localparam logic signed [GW:0] HALF = (GW+1)'(1) <<< (SH-1);
  localparam logic signed [GW:0] MAXV = (GW+1)'(2**(DW-1) - 1);
  localparam logic signed [GW:0] MINV = -MAXV - (GW+1)'(1);

  logic [GW-1:0] i1, i2, i3;
  logic [GW-1:0] c1, c2, c3;
  logic [GW-1:0] d1, d2, d3;
  logic signed [GW:0] rnd, shr;
  logic signed [DW-1:0] y_n;

  always_comb begin
    rnd = {c3[GW-1], c3} + HALF;
    shr = rnd >>> SH;
    y_n = shr[DW-1:0];
    if (shr > MAXV)      y_n = MAXV[DW-1:0];
    else if (shr < MINV) y_n = MINV[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1 <= '0; i2 <= '0; i3 <= '0;
      c1 <= '0; c2 <= '0; c3 <= '0;
      d1 <= '0; d2 <= '0; d3 <= '0;
      y  <= '0;
    end else if (clr) begin
      i1 <= '0; i2 <= '0; i3 <= '0;
      c1 <= '0; c2 <= '0; c3 <= '0;
      d1 <= '0; d2 <= '0; d3 <= '0;
      y  <= '0;
    end else begin
      if (in_valid) begin
        i1 <= i1 + {{SH{x[DW-1]}}, x};
        i2 <= i2 + i1;
        i3 <= i3 + i2;
      end
      // each comb fires once per output, one cycle after the previous one
      if (en[0]) begin c1 <= i3 - d1; d1 <= i3; end
      if (en[1]) begin c2 <= c1 - d2; d2 <= c1; end
      if (en[2]) begin c3 <= c2 - d3; d3 <= c2; end
      if (en[3]) y <= y_n;
    end
  end

endmodule

// File: rtl/mix_cic_dec.sv
// Four-channel CIC decimator: shared decimation counter, strobe/comb-enable
// shift register and OUT_VALID; four identical mix_cic_ch datapaths.
module mix_cic_dec
  import mix_pkg::*;
#(
  parameter int DW    = SAMPLE_W,
  parameter int RLOG2 = CIC_RLOG2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                CLR,
  mix_cic_dec_if.slave        bus
);

  logic [RLOG2-1:0] cnt;
  logic [3:0]       stb_sr;
  logic             out_valid;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt       <= '0;
      stb_sr    <= '0;
      out_valid <= 1'b0;
    end else if (CLR) begin
      cnt       <= '0;
      stb_sr    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (bus.IN_VALID) cnt <= cnt + 1'b1;
      // bit 0 is the strobe S; bits 1..3 walk it through combs 2, 3 and the output
      stb_sr    <= {stb_sr[2:0], bus.IN_VALID && (cnt == '1)};
      out_valid <= stb_sr[3];
    end
  end

  assign bus.OUT_VALID = out_valid;

  mix_cic_ch #(.DW(DW), .RLOG2(RLOG2)) u_ch0 (
    .clk(CLK), .rst_n(RST_N), .clr(CLR), .in_valid(bus.IN_VALID),
    .x(bus.MIX1_DATI), .en(stb_sr), .y(bus.BB1_DATI)
  );

  mix_cic_ch #(.DW(DW), .RLOG2(RLOG2)) u_ch1 (
    .clk(CLK), .rst_n(RST_N), .clr(CLR), .in_valid(bus.IN_VALID),
    .x(bus.MIX1_DATQ), .en(stb_sr), .y(bus.BB1_DATQ)
  );

  mix_cic_ch #(.DW(DW), .RLOG2(RLOG2)) u_ch2 (
    .clk(CLK), .rst_n(RST_N), .clr(CLR), .in_valid(bus.IN_VALID),
    .x(bus.MIX2_DATI), .en(stb_sr), .y(bus.BB2_DATI)
  );

  mix_cic_ch #(.DW(DW), .RLOG2(RLOG2)) u_ch3 (
    .clk(CLK), .rst_n(RST_N), .clr(CLR), .in_valid(bus.IN_VALID),
    .x(bus.MIX2_DATQ), .en(stb_sr), .y(bus.BB2_DATQ)
  );

endmodule

// File: tb/tb_mix_cic_dec.sv
// Bench for mix_cic_dec: closed-form CIC model over the accepted-sample history,
// a per-cycle compare process, and directed scenarios with literal expectations.
module tb_mix_cic_dec;
  import mix_pkg::*;

  localparam int R  = 16;
  localparam int SH = 12;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic CLR = 1'b0;
  always #5 CLK = ~CLK;

  mix_cic_dec_if bus();

  mix_cic_dec #(.DW(16), .RLOG2(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic sample_t in_of(input int c);
    case (c)
      0: return bus.MIX1_DATI;
      1: return bus.MIX1_DATQ;
      2: return bus.MIX2_DATI;
      default: return bus.MIX2_DATQ;
    endcase
  endfunction

  function automatic sample_t out_of(input int c);
    case (c)
      0: return bus.BB1_DATI;
      1: return bus.BB1_DATQ;
      2: return bus.BB2_DATI;
      default: return bus.BB2_DATQ;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  // Accepted samples since reset/clear; the third integrator after n samples is
  // sum x[m]*C(n-m,2), and output k is the R-spaced third difference of that.
  longint xs[4][$];
  typedef struct {
    int              due;
    logic [3:0][15:0] v;
  } ev_t;
  ev_t pend[$];
  int  ec = 0;
  logic exp_valid = 1'b0;
  logic signed [15:0] exp_bb [4] = '{default: 16'sd0};

  function automatic longint i3_at(input int c, input int n);
    longint s, w;
    s = 0;
    if (n < 3) return 0;
    for (int m = 1; m <= n - 2; m++) begin
      w = longint'(n - m) * longint'(n - m - 1) / 2;
      s += xs[c][m-1] * w;
    end
    return s;
  endfunction

  function automatic logic [15:0] model_out(input int c, input int k);
    longint n, acc, q;
    n   = longint'(k) * R;
    acc = i3_at(c, int'(n)) - 3 * i3_at(c, int'(n - R))
        + 3 * i3_at(c, int'(n - 2*R)) - i3_at(c, int'(n - 3*R));
    q = (acc + (64'sd1 <<< (SH-1))) >>> SH;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      xs[c].delete();
      exp_bb[c] = 16'sd0;
    end
    pend.delete();
    exp_valid = 1'b0;
  endtask

  always @(posedge CLK or negedge RST_N) begin
    ev_t e;
    if (!RST_N) begin
      model_clear();
    end else begin
      if (CLR) begin
        model_clear();
      end else begin
        if (bus.IN_VALID) begin
          for (int c = 0; c < 4; c++) xs[c].push_back(longint'(in_of(c)));
          if (xs[0].size() % R == 0) begin
            e.due = ec + 4;
            for (int c = 0; c < 4; c++) e.v[c] = model_out(c, xs[0].size() / R);
            pend.push_back(e);
          end
        end
        exp_valid = 1'b0;
        if (pend.size() > 0 && pend[0].due == ec) begin
          exp_valid = 1'b1;
          for (int c = 0; c < 4; c++) exp_bb[c] = pend[0].v[c];
          void'(pend.pop_front());
        end
      end
      ec++;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      chk("out_valid", longint'(bus.OUT_VALID), longint'(exp_valid));
      for (int c = 0; c < 4; c++)
        chk($sformatf("bb%0d", c), longint'(out_of(c)), longint'(exp_bb[c]));
    end
  end

  // ---------------- stimulus ----------------
  int  amp [4] = '{default: 0};
  bit  alt = 0, sgn = 0, rnd = 1, ivtog = 0;

  task automatic step();
    @(negedge CLK);
    if (alt && bus.IN_VALID) sgn = ~sgn;
    bus.IN_VALID = ivtog ? ~bus.IN_VALID : 1'b1;
    bus.MIX1_DATI = rnd ? sample_t'($urandom) : sample_t'(sgn ? -amp[0] : amp[0]);
    bus.MIX1_DATQ = rnd ? sample_t'($urandom) : sample_t'(sgn ? -amp[1] : amp[1]);
    bus.MIX2_DATI = rnd ? sample_t'($urandom) : sample_t'(sgn ? -amp[2] : amp[2]);
    bus.MIX2_DATQ = rnd ? sample_t'($urandom) : sample_t'(sgn ? -amp[3] : amp[3]);
  endtask

  task automatic wait_pulse(output int n, input int lim);
    n = 0;
    forever begin
      step();
      n++;
      if (bus.OUT_VALID) return;
      if (n >= lim) begin
        chk("pulse_timeout", n, -1);
        return;
      end
    end
  endtask

  task automatic chk_all(input string name, input int v0, input int v1, input int v2, input int v3);
    chk({name, "_0"}, longint'(bus.BB1_DATI), v0);
    chk({name, "_1"}, longint'(bus.BB1_DATQ), v1);
    chk({name, "_2"}, longint'(bus.BB2_DATI), v2);
    chk({name, "_3"}, longint'(bus.BB2_DATQ), v3);
  endtask

  // Clear, then wait four pulses: first after 20 clocks, then at the given period.
  task automatic clear_settle(input string name, input int period);
    int n;
    step(); CLR = 1'b1;
    step(); CLR = 1'b0;
    wait_pulse(n, 60);
    chk({name, "_first"}, n, 20);
    for (int k = 0; k < 3; k++) begin
      wait_pulse(n, 60);
      chk({name, "_period"}, n, period);
    end
  endtask

  task automatic wait_count(input int want);
    for (int i = 0; i < 64; i++) begin
      if (xs[0].size() % R == want) return;
      step();
    end
    chk("count_timeout", xs[0].size() % R, want);
  endtask

  initial begin
    int n;
    bus.IN_VALID = 1'b0;
    bus.MIX1_DATI = '0; bus.MIX1_DATQ = '0; bus.MIX2_DATI = '0; bus.MIX2_DATQ = '0;

    // 1: reset with random inputs, then first pulse exactly 20 clocks after release
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rst_ov", longint'(bus.OUT_VALID), 0);
      chk_all("rst_bb", 0, 0, 0, 0);
    end
    amp = '{1000, 1000, 1000, 1000};
    rnd = 0;
    step(); RST_N = 1'b1;
    wait_pulse(n, 60);
    chk("rel_first", n, 20);

    // 2: constant 1000, 16-clock period, exact from the 4th pulse
    for (int k = 0; k < 3; k++) begin
      wait_pulse(n, 60);
      chk("dc_period", n, 16);
    end
    chk_all("dc1000", 1000, 1000, 1000, 1000);
    wait_pulse(n, 60);
    chk_all("dc1000_5", 1000, 1000, 1000, 1000);

    // 3: full-scale extremes
    amp = '{32767, -32768, 32767, -32768};
    clear_settle("fs", 16);
    chk_all("fullscale", 32767, -32768, 32767, -32768);

    // 4: fs/2 alternation, then every-other-clock valid
    amp = '{1000, 1000, 1000, 1000};
    alt = 1;
    clear_settle("alt", 16);
    chk_all("alt", 0, 0, 0, 0);
    ivtog = 1;
    wait_pulse(n, 60);
    for (int k = 0; k < 4; k++) begin
      wait_pulse(n, 80);
      chk("half_rate_period", n, 32);
    end
    chk_all("alt_half", 0, 0, 0, 0);
    ivtog = 0;
    alt = 0;

    // 5: one-cycle reset at counter 7 while settled
    clear_settle("pre_rst", 16);
    chk_all("pre_rst", 1000, 1000, 1000, 1000);
    wait_count(7);
    @(negedge CLK); RST_N = 1'b0;
    #1;
    chk_all("midrst", 0, 0, 0, 0);
    chk("midrst_ov", longint'(bus.OUT_VALID), 0);
    step(); RST_N = 1'b1;
    wait_pulse(n, 60);
    chk("rst7_first", n, 20);
    for (int k = 0; k < 3; k++) wait_pulse(n, 60);
    chk_all("rst7_back", 1000, 1000, 1000, 1000);

    // 6: CLR on the R-th sample drops it and restarts the counter
    wait_count(15);
    CLR = 1'b1;
    step(); CLR = 1'b0;
    chk_all("clr_bb", 0, 0, 0, 0);
    wait_pulse(n, 60);
    chk("clr_first", n, 20);

    repeat (4) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mix_cic_dec.md
Name: mix_cic_dec

Overview:
- Four-channel CIC decimation filter directly downstream of the I/Q mixer stage.
- Consumes the mixer's two I/Q pairs (MIX1_DATI/Q, MIX2_DATI/Q) at the full ADC clock rate.
- Low-pass filters each channel, decimates by R and rescales to 16-bit.
- Outputs baseband I/Q at CLK/R with a one-cycle valid strobe for the phase/error stage that feeds the PID loop.

Parameters:
- DW, 16: input/output sample width, signed two's complement.
- RLOG2, 4: log2 of the decimation ratio R. R = 2^RLOG2 = 16. Legal range 2..8, so R >= 4.
- N, 3: CIC order. Fixed at 3 and not overridable.
- GW, DW+3*RLOG2 (28): internal integrator/comb width. Derived, not overridable.

Ports:
- CLK  in  1  system clock; the only clock.
- RST_N  in  1  asynchronous, active-low reset.
- CLR  in  1  synchronous clear of all filter state. Priority over IN_VALID.
- IN_VALID  in  1  input sample strobe. Tie high for full-rate mixer output.
- MIX1_DATI  in  16  channel 0 input, signed.
- MIX1_DATQ  in  16  channel 1 input, signed.
- MIX2_DATI  in  16  channel 2 input, signed.
- MIX2_DATQ  in  16  channel 3 input, signed.
- BB1_DATI  out  16  channel 0 decimated output, signed.
- BB1_DATQ  out  16  channel 1 decimated output, signed.
- BB2_DATI  out  16  channel 2 decimated output, signed.
- BB2_DATQ  out  16  channel 3 decimated output, signed.
- OUT_VALID  out  1  one-cycle pulse; outputs are new this cycle.

Behaviour:
- Clocking and reset (decided): one clock; reset is asynchronous and active-low. RST_N low clears every register immediately.
- Reset values: all BB* outputs = 0, OUT_VALID = 0, decimation counter = 0, all integrator and comb state = 0.
- CLR high at a clock edge produces the same state as reset on that edge. The input sample presented in that cycle is discarded.
- Integrators: three cascaded per channel, each GW bits, clocked only when IN_VALID = 1.
  - Operations: I1 += sext(x); I2 += I1; I3 += I2.
  - Each stage uses the pre-edge value of the previous stage (registered chain).
  - Overflow wraps modulo 2^GW by design. No saturation.
- IN_VALID = 0: integrators and counter hold. Comb pipeline and OUT_VALID are unaffected, so an in-flight output still completes.
- Decimation counter: 0..R-1, advances on each IN_VALID and wraps to 0.
  - The IN_VALID cycle with counter = R-1 is cycle t.
  - t+1: internal strobe S; I3 is sampled.
  - t+1, t+2, t+3: comb stages 1, 2, 3 each evaluate once. Ck = in - Dk, with Dk <= in, all GW-bit wrap arithmetic.
  - t+4: rescaled result registered into BB*, OUT_VALID = 1 for exactly one cycle.
- Latency: OUT_VALID is high 4 clocks after the R-th accepted sample. OUT_VALID period = R accepted samples, so 16 clocks when IN_VALID is always high. BB* holds between pulses.
- Rescale: DC gain is R^3 = 2^(3*RLOG2).
  - out = (C3 + 2^(3*RLOG2-1)) >>> 3*RLOG2, i.e. round half up.
  - Then saturate to [-32768, 32767]. Saturation is a guard only and is unreachable in steady state.
- All four channels share the counter and strobe, so outputs are always sample-aligned.
- Steady state: constant input x yields out = x exactly from the 4th OUT_VALID after reset or CLR onward.

Decomposition:
- Shared package mix_pkg holds:
  - constants CIC_N = 3, CIC_RLOG2 = 4, derived CIC_GW;
  - a signed 16-bit sample typedef used by mix_pro and this block.
- Sub-module mix_cic_ch: one channel's 3 integrators, 3 combs with delay registers, and the round/saturate stage.
  - Driven by IN_VALID, CLR and the comb-stage enables.
  - Instantiated 4 times.
- Top-level mix_cic_dec owns the decimation counter, strobe and comb-enable shift register, and OUT_VALID.

Test Plan:
1. Hold RST_N low with random inputs -> all BB* = 0 and OUT_VALID = 0; release, no pulse before 16+4 clocks.
2. Constant 1000 on all four inputs, IN_VALID = 1 -> OUT_VALID every 16 clocks; the 4th and later pulses give 1000 on every output.
3. Constant +32767 on ch0/ch2 and -32768 on ch1/ch3 -> settled outputs exactly +32767/-32768, with no wrap or sign flip.
4. Alternating +1000/-1000 per sample (fs/2) -> settled outputs exactly 0. IN_VALID high every other clock -> OUT_VALID period 32, values unchanged.
5. RST_N low for 1 cycle at counter = 7 while settled at 1000 -> outputs 0 at once. Next OUT_VALID comes 16+4 clocks after release, and the value 1000 returns on the 4th pulse.
6. CLR = 1 coincident with IN_VALID at counter = R-1 -> sample dropped, no OUT_VALID at t+4, counter restarts at 0.
